// File: rtl/gf180mcu_osu_sc_gp12t3v3_strap_capture.sv
`timescale 1ns/10ps
// Strap capture: synchronizes reset release, waits a settle window, then qualifies
// and locks the tie-cell strap bus once it has been seen stable for several samples.
module gf180mcu_osu_sc_gp12t3v3_strap_capture #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 3,
    parameter int unsigned MAX_RETRY     = 15
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] STRAP,
    input  logic             RELOAD,
    output logic [WIDTH-1:0] CFG,
    output logic             VALID,
    output logic             FAULT,
    output logic [3:0]       RETRY,
    output logic             RSTN_SYNC
);
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned CNT_W    = 4;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SAMPLES_N   = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0]    RETRY_MAX   = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]    RETRY_SAT   = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_LOCKED,
        ST_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    match_inc;
    logic [CNT_W-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0]    retry_inc;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic [WIDTH-1:0]    cfg_q, cfg_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;

    // Reset synchronizer: asserts with RN, releases two edges later
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            retry_q      <= '0;
            shadow_q     <= '0;
            cfg_q        <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            retry_q      <= retry_d;
            shadow_q     <= shadow_d;
            cfg_q        <= cfg_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        retry_d      = retry_q;
        shadow_d     = shadow_q;
        cfg_d        = cfg_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        match_inc    = match_cnt_q + CNT_W'(1);
        retry_inc    = (retry_q == RETRY_SAT) ? retry_q : retry_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d     = ST_SAMPLE;
                    shadow_d    = STRAP;
                    match_cnt_d = CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                // An X/Z strap makes the equality untrue and lands in the mismatch path
                if (STRAP == shadow_q) begin
                    match_cnt_d = match_inc;
                    if (match_inc == SAMPLES_N) begin
                        cfg_d   = shadow_q;
                        valid_d = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end else begin
                    shadow_d    = STRAP;
                    match_cnt_d = CNT_W'(1);
                    retry_d     = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_LOCKED, ST_FAULT: begin
                // CFG deliberately survives a reload until the next lock
                if (RELOAD) begin
                    valid_d      = 1'b0;
                    fault_d      = 1'b0;
                    retry_d      = '0;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign CFG       = cfg_q;
    assign VALID     = valid_q;
    assign FAULT     = fault_q;
    assign RETRY     = retry_q;
    assign RSTN_SYNC = sync2_q;

endmodule
